// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register pending-write scoreboard.
// NUM_RD combinational read ports, one writeback port, and a saturating
// pending counter per register that hazard logic uses to stall on in-flight
// destinations.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle
// writeback onto matching read ports.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_dest,
  output logic                     iss_ready,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  output logic                     busy_any
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Flattened views of the per-register state, driven from the generate loop
  logic [NUM_REGS-1:0][DATA_W-1:0] data_arr;
  logic [NUM_REGS-1:0][PEND_W-1:0] cnt_arr;
  logic [NUM_REGS-1:0]             busy_vec;
  logic [PEND_W-1:0]               iss_cnt;

  // Count of the issue target; out-of-range targets read as 0, so they are always ready
  always_comb begin
    iss_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (iss_dest == ADDR_W'(i)) iss_cnt = cnt_arr[i];
    end
  end

  assign iss_ready = (iss_cnt != PEND_MAX);
  assign busy_any  = |busy_vec;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic              wb_hit;
    logic              iss_hit;
    logic [DATA_W-1:0] data_reg;
    logic [PEND_W-1:0] cnt_reg;
    logic [PEND_W-1:0] cnt_next;

    assign wb_hit  = wb_en && (wb_dest == ADDR_W'(gi));
    assign iss_hit = iss_en && iss_ready && (iss_dest == ADDR_W'(gi));

    // Next pending count: flush wins, an issue and a writeback on the same
    // register cancel out, and a writeback never drives the count below zero
    always_comb begin
      cnt_next = cnt_reg;
      if (flush) begin
        cnt_next = '0;
      end else if (iss_hit && !wb_hit) begin
        cnt_next = cnt_reg + PEND_W'(1);
      end else if (wb_hit && !iss_hit && (cnt_reg != '0)) begin
        cnt_next = cnt_reg - PEND_W'(1);
      end
    end

    // Register data and pending count; reset loads each register with its own index
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= DATA_W'(gi);
        cnt_reg  <= '0;
      end else begin
        if (wb_hit) data_reg <= wb_data;
        cnt_reg <= cnt_next;
      end
    end

    assign data_arr[gi] = data_reg;
    assign cnt_arr[gi]  = cnt_reg;
    assign busy_vec[gi] = (cnt_reg != '0);
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W:0] NREGS_EXT = (ADDR_W+1)'(NUM_REGS);
`endif

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_mux;
    logic [PEND_W-1:0] cnt_mux;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

    // Read mux over stored state; unimplemented addresses return 0 / not pending
    always_comb begin
      data_mux = '0;
      cnt_mux  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == ADDR_W'(i)) begin
          data_mux = data_arr[i];
          cnt_mux  = cnt_arr[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the writeback and report the count as it will be after this write
      if (wb_en && (wb_dest == addr) && ({1'b0, addr} < NREGS_EXT)) begin
        data_mux = wb_data;
        cnt_mux  = (cnt_mux != '0) ? cnt_mux - PEND_W'(1) : '0;
      end
`endif
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data_mux;
    assign rd_pending[gi]               = (cnt_mux != '0);
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated per-register write scoreboard. It sits between the decode/issue stage and the writeback stage of the ARM pipeline. It provides NUM_RD combinational read ports, one writeback port, and a pending-write counter per register, so hazard logic can stall on in-flight destinations without a separate unit. Writes happen on the rising clock edge. Same-cycle write-to-read forwarding is a compile-time option.

## Interface
- DATA_W, 32, register width
- ADDR_W, 4, register address width
- NUM_REGS, 15, implemented registers (indices 0..NUM_REGS-1, NUM_REGS <= 2**ADDR_W)
- NUM_RD, 2, number of read ports
- PEND_W, 2, pending-counter width per register (max outstanding = 2**PEND_W-1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_pending  out  NUM_RD  port k: addressed register has an outstanding write
- iss_en  in  1  issue: mark iss_dest as pending
- iss_dest  in  ADDR_W  issued destination
- iss_ready  out  1  issue accepted this cycle
- wb_en  in  1  writeback strobe
- wb_dest  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- flush  in  1  clear all pending counters
- busy_any  out  1  OR of all pending counters nonzero

## Operation
- Storage: NUM_REGS x DATA_W registers and NUM_REGS x PEND_W counters cnt[i].
- Reset (rst_n low, asynchronous): reg[i] = i, truncated to DATA_W. All cnt = 0. Outputs settle accordingly: busy_any=0, iss_ready=1, rd_pending=0.
- Read: rd_data[k] = reg[rd_addr[k]]; rd_pending[k] = (cnt[rd_addr[k]] != 0). If the address is >= NUM_REGS, data is 0 and pending is 0.
- Writeback: when wb_en=1 and wb_dest < NUM_REGS, the rising edge sets reg[wb_dest] = wb_data. If cnt[wb_dest] > 0 it decrements; it never underflows. Writes to wb_dest >= NUM_REGS are ignored.
- Issue: iss_ready = (iss_dest >= NUM_REGS) or (cnt[iss_dest] != max). When iss_en=1, iss_ready=1 and iss_dest < NUM_REGS, cnt[iss_dest] increments. An issue with iss_ready=0 is dropped and the issuer must hold.
- Issue and writeback to the same register in one cycle: counter unchanged, data written. iss_ready is still computed from the current count, so a saturated counter blocks issue even when a writeback hits the same register.
- Flush: all cnt become 0 at the edge. Flush has priority over a same-cycle issue, which is dropped. A same-cycle writeback still writes its data.
- busy_any is registered-state derived (combinational OR of cnt), with no input paths.

## Timing
- Read ports: combinational, 0-cycle latency from rd_addr.
- Written data is visible on reads in the cycle after the wb edge. Same-cycle visibility is available only under the macro below.
- Pending: rd_pending rises in the cycle after the accepted issue edge and falls in the cycle after the final matching writeback edge.
- iss_ready: combinational from iss_dest and current cnt.
- Reset mid-operation: in-flight state is discarded. Writebacks arriving after reset deassertion write data and leave cnt at 0.

## Configuration
- REGFILE_BYPASS_EN defined: if wb_en=1 and wb_dest == rd_addr[k] < NUM_REGS, then rd_data[k] = wb_data in the same cycle. In that case rd_pending[k] reports (cnt - 1) != 0, i.e. the count after this writeback.
- REGFILE_BYPASS_EN undefined: no forwarding. rd_data and rd_pending reflect only stored state.

## Test plan
- Reset: assert rst_n=0 mid-cycle; then rd_addr port0=3, port1=14 -> rd_data 3 and 14 immediately, busy_any=0, iss_ready=1.
- Issue/writeback: issue r5; next cycle rd_pending[r5]=1. Writeback r5=0xDEADBEEF -> following cycle rd_data=0xDEADBEEF and rd_pending=0.
- Saturation: issue r2 three times (PEND_W=2) -> iss_ready=0 for r2, and a fourth issue leaves cnt=3. One writeback brings cnt to 2 and iss_ready to 1.
- Same-cycle events: cnt[r7]=1, then iss r7 + wb r7 in one cycle -> cnt stays 1. Flush + iss r4 in one cycle -> all cnt 0 and busy_any=0 next cycle.
- Bypass (macro defined): wb r1=0x55 with rd_addr port0=r1 -> rd_data=0x55 in the same cycle. With the macro undefined -> old value that cycle, 0x55 the next.
- Out of range: read r15 -> 0 and pending 0. Writeback r15 and issue r15 -> no state change, iss_ready=1.
